// File: rtl/simt_pdom_scheduler.sv
// Per-core SIMT control FSM with a post-dominator reconvergence stack.
// It splits divergent branches into two paths, reconverges at the compiler-supplied PC and retires lanes on RET.
module simt_pdom_scheduler #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int STACK_DEPTH           = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic                                               decoded_ret,
    input  logic [1:0]                                         decoded_pc_mux,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]                   decoded_reconv_pc,
    input  logic [2:0]                                         fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
    input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]                       active_mask,
    output logic [2:0]                                         core_state,
    output logic                                               done,
    output logic [$clog2(STACK_DEPTH+1)-1:0]                   stack_depth,
    output logic                                               overflow_error
);
    localparam int T    = THREADS_PER_BLOCK;
    localparam int PCW  = PROGRAM_MEM_ADDR_BITS;
    localparam int SDW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic [T-1:0]     mask_q, mask_d;
    logic [T-1:0]     exited_q, exited_d;
    logic [PCW-1:0]   rpc_q, rpc_d;
    logic             rpc_valid_q, rpc_valid_d;
    logic [SDW-1:0]   sp_q, sp_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [PCW-1:0]   stk_pc_q        [STACK_DEPTH];
    logic [T-1:0]     stk_mask_q      [STACK_DEPTH];
    logic [PCW-1:0]   stk_rpc_q       [STACK_DEPTH];
    logic             stk_rpc_valid_q [STACK_DEPTH];

    logic [IDXW-1:0]  tos_idx, push_lo_idx, push_hi_idx;
    logic [PCW-1:0]   tos_pc, tos_rpc;
    logic [T-1:0]     tos_mask;
    logic             tos_rpc_valid;
    logic             push_en;

    logic [PCW-1:0]   fallthrough, target, npc_uniform, lane_npc;
    logic [T-1:0]     taken, not_taken;
    logic             found_taken, found_active, lsu_busy;

    assign tos_idx       = IDXW'(sp_q - SDW'(1));
    assign push_lo_idx   = IDXW'(sp_q);
    assign push_hi_idx   = IDXW'(sp_q + SDW'(1));
    assign tos_pc        = stk_pc_q[tos_idx];
    assign tos_mask      = stk_mask_q[tos_idx];
    assign tos_rpc       = stk_rpc_q[tos_idx];
    assign tos_rpc_valid = stk_rpc_valid_q[tos_idx];
    assign fallthrough   = pc_q + PCW'(1);

    // Lane classification only looks at active lanes; idle lanes carry stale next_pc.
    always_comb begin
        taken        = '0;
        not_taken    = '0;
        target       = '0;
        npc_uniform  = '0;
        lane_npc     = '0;
        found_taken  = 1'b0;
        found_active = 1'b0;
        lsu_busy     = 1'b0;
        for (int i = 0; i < T; i++) begin
            lane_npc = next_pc[i*PCW +: PCW];
            if (mask_q[i]) begin
                if (lane_npc != fallthrough) begin
                    taken[i] = 1'b1;
                    if (!found_taken) begin
                        target      = lane_npc;
                        found_taken = 1'b1;
                    end
                end else begin
                    not_taken[i] = 1'b1;
                end
                if (!found_active) begin
                    npc_uniform  = lane_npc;
                    found_active = 1'b1;
                end
                if (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10) begin
                    lsu_busy = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mask_d      = mask_q;
        exited_d    = exited_q;
        rpc_d       = rpc_q;
        rpc_valid_d = rpc_valid_q;
        sp_d        = sp_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        push_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    mask_d      = '1;
                    exited_d    = '0;
                    sp_d        = '0;
                    rpc_valid_d = 1'b0;
                end
            end
            S_FETCH:   if (fetcher_state == 3'b010) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!lsu_busy) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                if (decoded_ret || mask_q == '0) begin
                    exited_d = exited_q | mask_q;
                    if (sp_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d        = tos_pc;
                        mask_d      = tos_mask & ~exited_d;
                        rpc_d       = tos_rpc;
                        rpc_valid_d = tos_rpc_valid;
                        sp_d        = sp_q - SDW'(1);
                        // An all-retired entry is popped again on the next cycle.
                        state_d     = (mask_d == '0) ? S_UPDATE : S_FETCH;
                    end
                end else if (decoded_pc_mux == 2'd1 && (|taken) && (|not_taken)) begin
                    if (sp_q > SDW'(STACK_DEPTH - 2)) begin
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        push_en     = 1'b1;
                        sp_d        = sp_q + SDW'(2);
                        pc_d        = target;
                        mask_d      = taken;
                        rpc_d       = decoded_reconv_pc;
                        rpc_valid_d = 1'b1;
                        state_d     = S_FETCH;
                    end
                end else begin
                    if (rpc_valid_q && npc_uniform == rpc_q && sp_q != '0) begin
                        pc_d        = tos_pc;
                        mask_d      = tos_mask & ~exited_q;
                        rpc_d       = tos_rpc;
                        rpc_valid_d = tos_rpc_valid;
                        sp_d        = sp_q - SDW'(1);
                    end else begin
                        pc_d = npc_uniform;
                    end
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mask_q      <= '1;
            exited_q    <= '0;
            rpc_q       <= '0;
            rpc_valid_q <= 1'b0;
            sp_q        <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mask_q      <= mask_d;
            exited_q    <= exited_d;
            rpc_q       <= rpc_d;
            rpc_valid_q <= rpc_valid_d;
            sp_q        <= sp_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    // Lower entry resumes the pre-branch path at the reconvergence PC; upper entry is the not-taken path.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stk_pc_q[push_lo_idx]        <= decoded_reconv_pc;
            stk_mask_q[push_lo_idx]      <= mask_q;
            stk_rpc_q[push_lo_idx]       <= rpc_q;
            stk_rpc_valid_q[push_lo_idx] <= rpc_valid_q;
            stk_pc_q[push_hi_idx]        <= fallthrough;
            stk_mask_q[push_hi_idx]      <= not_taken;
            stk_rpc_q[push_hi_idx]       <= decoded_reconv_pc;
            stk_rpc_valid_q[push_hi_idx] <= 1'b1;
        end
    end

    assign current_pc     = pc_q;
    assign active_mask    = mask_q;
    assign core_state     = state_q;
    assign done           = done_q;
    assign stack_depth    = sp_q;
    assign overflow_error = ovf_q;

endmodule
